// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: radix-2, one bit per cycle,
// owns the HiLo write port and stalls the pipeline around in-flight operations.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [1:0]              Op,
    input  logic [DATA_WIDTH-1:0]   OpA,
    input  logic [DATA_WIDTH-1:0]   OpB,
    input  logic                    HiLoReadReq,
    output logic                    Stall,
    output logic                    Busy,
    output logic                    HiLoEn,
    output logic [2*DATA_WIDTH-1:0] HiLoWrite,
    output logic                    DivByZero
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic            op_div;
    logic            neg_res;
    logic            neg_rem;
    logic [W-1:0]    opnd;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;

    logic            signed_in;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [W:0]      rem_sh, rem_diff;
    logic [2*W-1:0]  mul_next, div_next, step_next;
    logic [W-1:0]    quo, rem;
    logic [2*W-1:0]  prod_fix;
    logic [2*W-1:0]  result;

    assign signed_in = ~Op[0];
    assign mag_a = (signed_in && OpA[W-1]) ? -OpA : OpA;
    assign mag_b = (signed_in && OpB[W-1]) ? -OpB : OpB;

    // opnd holds the multiplicand for multiplies and the divisor for divides
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[W-1:1]};
        rem_sh    = acc[2*W-1:W-1];
        rem_diff  = rem_sh - {1'b0, opnd};
        if (rem_sh >= {1'b0, opnd})
            div_next = {rem_diff[W-1:0], acc[W-2:0], 1'b1};
        else
            div_next = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
        step_next = op_div ? div_next : mul_next;
        quo       = neg_res ? -step_next[W-1:0]     : step_next[W-1:0];
        rem       = neg_rem ? -step_next[2*W-1:W]   : step_next[2*W-1:W];
        prod_fix  = neg_res ? -step_next : step_next;
        result    = op_div ? {rem, quo} : prod_fix;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            op_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            cnt       <= '0;
            HiLoEn    <= 1'b0;
            DivByZero <= 1'b0;
            HiLoWrite <= '0;
        end else begin
            HiLoEn    <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_div  <= Op[1];
                        neg_res <= signed_in & (OpA[W-1] ^ OpB[W-1]);
                        neg_rem <= signed_in & OpA[W-1];
                        cnt     <= '0;
                        if (Op[1]) begin
                            opnd <= mag_b;
                            acc  <= {{W{1'b0}}, mag_a};
                            if (OpB == '0) begin
                                // divide by zero skips the iteration entirely
                                state     <= DONE;
                                HiLoEn    <= 1'b1;
                                DivByZero <= 1'b1;
                                HiLoWrite <= {OpA, {W{1'b1}}};
                            end else begin
                                state <= RUN;
                            end
                        end else begin
                            opnd  <= mag_a;
                            acc   <= {{W{1'b0}}, mag_b};
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state     <= DONE;
                        HiLoEn    <= 1'b1;
                        HiLoWrite <= result;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy  = (state != IDLE);
    assign Stall = Busy & (Start | HiLoReadReq);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        HiLoReadReq = 1'b0;
    logic        Stall, Busy, HiLoEn, DivByZero;
    logic [63:0] HiLoWrite;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .HiLoReadReq(HiLoReadReq), .Stall(Stall), .Busy(Busy), .HiLoEn(HiLoEn),
        .HiLoWrite(HiLoWrite), .DivByZero(DivByZero)
    );

    always #5 Clock = ~Clock;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] ua, ub, m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        m  = '0;
        case (op)
            2'b00: begin p = sa * sb; m = p; end
            2'b01: m = ua * ub;
            2'b10: begin
                if (b == 0) m = {a, 32'hFFFFFFFF};
                else begin q = sa / sb; r = sa % sb; m = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 0) m = {a, 32'hFFFFFFFF};
                else m = {a % b, a / b};
            end
        endcase
        return m;
    endfunction

    // Drive Start for one cycle (cycle T); returns at the falling edge of T+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clock);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // Waits (bounded) for HiLoEn; lat = k where the pulse is seen in T+k, 0 on timeout.
    task automatic collect(output int lat, output logic [63:0] w, output logic dz);
        lat = 0; w = '0; dz = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (HiLoEn === 1'b1) begin
                lat = k; w = HiLoWrite; dz = DivByZero;
                break;
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clock);
        checks++;
        if ({Stall, Busy, HiLoEn, DivByZero} !== 4'b0 || HiLoWrite !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: got stall/busy/en/dz=%b hilo=%h, need 0000 and 0",
                     {Stall, Busy, HiLoEn, DivByZero}, HiLoWrite);
        end
        Reset = 1'b1;
    endtask

    task automatic test_multu_max;
        logic busy_exp, en_exp;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 1; k <= 34; k++) begin
            busy_exp = (k <= 33);
            en_exp   = (k == 33);
            checks++;
            if (Busy !== busy_exp || HiLoEn !== en_exp) begin
                errors++;
                $display("FAIL multu_timing T+%0d: busy=%b en=%b, need busy=%b en=%b",
                         k, Busy, HiLoEn, busy_exp, en_exp);
            end
            if (k >= 33) begin
                checks++;
                if (HiLoWrite !== 64'hFFFFFFFE_00000001) begin
                    errors++;
                    $display("FAIL multu_value T+%0d: got %h, need fffffffe00000001", k, HiLoWrite);
                end
            end
            if (k < 34) @(negedge Clock);
        end
    endtask

    task automatic test_signed;
        int lat; logic [63:0] w; logic dz;
        issue(2'b00, 32'hFFFFFFFD, 32'd7);
        collect(lat, w, dz);
        checks++;
        if (lat != 33 || w !== 64'hFFFFFFFF_FFFFFFEB) begin
            errors++;
            $display("FAIL mult_neg: lat=%0d val=%h, need 33 ffffffffffffffeb", lat, w);
        end
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        collect(lat, w, dz);
        checks++;
        if (lat != 33 || w !== 64'hFFFFFFFF_FFFFFFFD || dz !== 1'b0) begin
            errors++;
            $display("FAIL div_neg: lat=%0d val=%h dz=%b, need 33 fffffffffffffffd 0", lat, w, dz);
        end
    endtask

    task automatic test_div_zero;
        int lat; logic [63:0] w; logic dz;
        issue(2'b11, 32'h12345678, 32'd0);
        collect(lat, w, dz);
        checks++;
        if (lat != 1 || w !== 64'h12345678_FFFFFFFF || dz !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL divzero_pulse: lat=%0d val=%h dz=%b busy=%b, need 1 12345678ffffffff 1 1",
                     lat, w, dz, Busy);
        end
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0 || HiLoEn !== 1'b0 || DivByZero !== 1'b0 || HiLoWrite !== 64'h12345678_FFFFFFFF) begin
            errors++;
            $display("FAIL divzero_after: busy=%b en=%b dz=%b val=%h, need 0 0 0 held",
                     Busy, HiLoEn, DivByZero, HiLoWrite);
        end
    endtask

    task automatic test_div_overflow;
        int lat; logic [63:0] w; logic dz;
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        collect(lat, w, dz);
        checks++;
        if (lat != 33 || w !== 64'h00000000_80000000 || dz !== 1'b0) begin
            errors++;
            $display("FAIL div_overflow: lat=%0d val=%h dz=%b, need 33 0000000080000000 0", lat, w, dz);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [63:0] w; logic dz; logic stall_exp;
        issue(2'b00, 32'd1234, 32'hFFFFF000);
        for (int k = 1; k <= 34; k++) begin
            HiLoReadReq = (k >= 5);
            if (k >= 10) begin
                Start = 1'b1; Op = 2'b11; OpA = 32'd1000; OpB = 32'd7;
            end
            #1;
            stall_exp = (k >= 5 && k <= 33);
            checks++;
            if (Stall !== stall_exp) begin
                errors++;
                $display("FAIL stall T+%0d: got %b, need %b", k, Stall, stall_exp);
            end
            if (k == 33) begin
                checks++;
                if (HiLoEn !== 1'b1 || HiLoWrite !== model(2'b00, 32'd1234, 32'hFFFFF000)) begin
                    errors++;
                    $display("FAIL first_op: en=%b val=%h, need 1 %h", HiLoEn, HiLoWrite,
                             model(2'b00, 32'd1234, 32'hFFFFF000));
                end
            end
            @(negedge Clock);
        end
        Start = 1'b0; HiLoReadReq = 1'b0;
        collect(lat, w, dz);
        checks++;
        if (lat != 33 || w !== {32'd6, 32'd142}) begin
            errors++;
            $display("FAIL held_op: lat=%0d val=%h, need 33 %h", lat, w, {32'd6, 32'd142});
        end
    endtask

    task automatic test_reset_mid_op;
        int lat; logic [63:0] w; logic dz; int en_seen;
        issue(2'b01, 32'hDEADBEEF, 32'h00C0FFEE);
        repeat (9) @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++;
        if ({Stall, Busy, HiLoEn, DivByZero} !== 4'b0 || HiLoWrite !== 64'd0) begin
            errors++;
            $display("FAIL reset_abort: stall/busy/en/dz=%b val=%h, need 0000 0",
                     {Stall, Busy, HiLoEn, DivByZero}, HiLoWrite);
        end
        en_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clock);
            if (k == 3) Reset = 1'b1;
            if (HiLoEn === 1'b1) en_seen++;
        end
        checks++;
        if (en_seen != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: saw %0d pulses, need 0", en_seen);
        end
        issue(2'b00, 32'h7FFFFFFF, 32'h80000000);
        collect(lat, w, dz);
        checks++;
        if (lat != 33 || w !== 64'hC0000000_80000000) begin
            errors++;
            $display("FAIL after_reset: lat=%0d val=%h, need 33 c000000080000000", lat, w);
        end
    endtask

    task automatic test_random;
        int lat, lat_exp; logic [63:0] w, exp_w; logic dz, dz_exp;
        logic [1:0] op; logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp_w   = model(op, a, b);
            dz_exp  = op[1] && (b == 0);
            lat_exp = dz_exp ? 1 : 33;
            issue(op, a, b);
            collect(lat, w, dz);
            checks++;
            if (lat != lat_exp || w !== exp_w || dz !== dz_exp) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d val=%h dz=%b, need %0d %h %b",
                         i, op, a, b, lat, w, dz, lat_exp, exp_w, dz_exp);
            end
            @(negedge Clock);
            checks++;
            if (HiLoEn !== 1'b0 || Busy !== 1'b0 || HiLoWrite !== exp_w) begin
                errors++;
                $display("FAIL random_after[%0d]: en=%b busy=%b val=%h, need 0 0 %h",
                         i, HiLoEn, Busy, HiLoWrite, exp_w);
            end
        end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_signed;
        test_div_zero;
        test_div_overflow;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller for the EX stage. It owns the HiLo register write port.
- It sequences MULT, MULTU, DIV and DIVU as a radix-2 iteration, one bit per cycle.
- It stalls the pipeline while a new mul/div or an MFHI/MFLO reaches EX before the previous result is committed.
- On completion it writes the 64-bit result to HiLo in a single-cycle write pulse.

Parameters:
- DATA_WIDTH, 32, operand width; iteration count equals DATA_WIDTH.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  EX holds a mul/div instruction with valid, forwarded operands.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OpA  in  DATA_WIDTH  rs operand, after forwarding.
- OpB  in  DATA_WIDTH  rt operand, after forwarding.
- HiLoReadReq  in  1  EX holds MFHI or MFLO.
- Stall  out  1  freeze PC, IF/ID and ID/EX; bubble EX/MEM.
- Busy  out  1  an operation is in flight.
- HiLoEn  out  1  HiLo write enable, one-cycle pulse.
- HiLoWrite  out  2*DATA_WIDTH  {Hi, Lo} write data.
- DivByZero  out  1  pulses together with HiLoEn when a divide had OpB == 0.

Behaviour:
- Reset (Reset == 0, asynchronous):
  - State goes to IDLE; counter and datapath registers clear.
  - Stall, Busy, HiLoEn and DivByZero go to 0; HiLoWrite goes to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start == 1 at cycle T accepts the operation.
  - Latch Op; latch |OpA| and |OpB| for signed ops, raw values for unsigned ops.
  - Record the sign fix-up flags; counter = 0.
  - Next state is RUN, or DONE directly if the op is a divide with OpB == 0.
- RUN:
  - Multiply: shift-add over a 64-bit product register.
  - Divide: restoring division over a 64-bit {remainder, quotient} register.
  - Counter increments each cycle; after DATA_WIDTH iterations (T+1..T+32) go to DONE.
- DONE (T+33):
  - HiLoEn = 1 for exactly one cycle; HiLoWrite carries the final value; next state IDLE.
  - HiLo is updated at the end of T+33.
- Sign fix-up, applied in DONE:
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
  - Unsigned ops: no fix-up.
- Results: Lo = quotient or product[31:0]; Hi = remainder or product[63:32].
- DIV of -2^31 by -1: quotient 0x80000000, remainder 0 (natural modulo-2^32 wrap, no trap).
- Divide by zero:
  - State goes IDLE → DONE, so HiLoEn is asserted at T+1.
  - Hi = OpA, Lo = 0xFFFFFFFF; DivByZero = 1 for that cycle.
- Busy = (state != IDLE); it is combinational from the state.
- Stall = Busy & (Start | HiLoReadReq).
  - Stall stays 1 through DONE, so a read in T+34 sees the new HiLo.
  - Stall is never asserted in IDLE.
- Start while Busy is ignored (no re-latch). The instruction is held by Stall and accepted in its first IDLE cycle.
- HiLoEn is only ever 1 in DONE. HiLoWrite holds its last value at all other times.
- Reset mid-operation aborts with no HiLoEn pulse. HiLo contents are untouched by this block.

Test Plan:
- MULTU OpA = OpB = 0xFFFFFFFF, Start at T → Busy T+1..T+33; HiLoEn only at T+33; HiLoWrite = 0xFFFFFFFE_00000001.
- MULT OpA = -3, OpB = 7 → HiLoWrite = 0xFFFFFFFF_FFFFFFEB at T+33. DIV OpA = -7, OpB = 2 → Hi = 0xFFFFFFFF, Lo = 0xFFFFFFFD.
- DIVU OpA = 0x12345678, OpB = 0 → HiLoEn and DivByZero at T+1; Hi = 0x12345678, Lo = 0xFFFFFFFF; Busy = 1 only at T+1.
- MULT in flight, HiLoReadReq = 1 from T+5 → Stall = 1 for T+5..T+33, 0 at T+34. Second Start held from T+10 → Stall = 1 until DONE; new op accepted at T+34.
- DIV OpA = 0x80000000, OpB = 0xFFFFFFFF → Lo = 0x80000000, Hi = 0, DivByZero = 0.
- Reset low at T+10 mid-MULTU → all outputs 0 immediately, no HiLoEn. After release, a Start is accepted normally with full T+33 latency.
